// File: rtl/dep_track_pipe_pkg.sv
// Shared types and constants for the AG/MR/EX/MW register-writer tracking pipe.
package dep_track_pipe_pkg;

  localparam int DEF_MODRM_W = 8;

  localparam int ST_AG    = 0;
  localparam int ST_MR    = 1;
  localparam int ST_EX    = 2;
  localparam int ST_MW    = 3;
  localparam int N_STAGES = 4;

  typedef struct packed {
    logic                   v;
    logic                   we;
    logic                   rmsel;
    logic [DEF_MODRM_W-1:0] modrm;
  } stage_entry_t;

endpackage

// File: rtl/dep_track_pipe_stage_reg.sv
// One tracked-pipe entry register {v, we, rmsel, modrm}: reset, kill (clear valid), hold, else load.
module dep_stage_reg #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         hold,
  input  logic         kill,
  input  logic [W-1:0] d_in,
  output logic [W-1:0] q
);

  logic [W-1:0] entry_q;
  logic [W-1:0] entry_d;

  // Kill only drops the valid bit; the payload may stay stale.
  always_comb begin
    entry_d = entry_q;
    if (kill) begin
      entry_d[W-1] = 1'b0;
    end else if (!hold) begin
      entry_d = d_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign q = entry_q;

endmodule

// File: rtl/dep_track_pipe.sv
// Tracks register writers in AG/MR/EX/MW, stalls decode and bubbles AG on reg_dep.
// Optional bubble counter enabled by defining DEP_STALL_CNT_EN.
module dep_track_pipe
  import dep_track_pipe_pkg::*;
#(
  parameter int MODRM_W = DEF_MODRM_W,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               de_v,
  input  logic               de_we,
  input  logic               de_rmsel,
  input  logic [MODRM_W-1:0] de_modrm,
  input  logic               reg_dep,
  input  logic               mem_stall,
  input  logic               flush,
  output logic               de_stall,
  output logic               ag_v,
  output logic               v_ag_we,
  output logic               v_mr_we,
  output logic               v_ex_we,
  output logic               v_mw_we,
  output logic               ag_rmsel,
  output logic               mr_rmsel,
  output logic               ex_rmsel,
  output logic               mw_rmsel,
  output logic [MODRM_W-1:0] ag_modrm,
  output logic [MODRM_W-1:0] mr_modrm,
  output logic [MODRM_W-1:0] ex_modrm,
  output logic [MODRM_W-1:0] mw_modrm,
  output logic [CNT_W-1:0]   bubble_cnt
);

  localparam int EW    = MODRM_W + 3;
  localparam int V_B   = EW - 1;
  localparam int WE_B  = EW - 2;
  localparam int RMS_B = EW - 3;

  logic [EW-1:0] stage_in [N_STAGES];
  logic [EW-1:0] stage_q  [N_STAGES];
  logic          bubble;

  // A bubble only happens on an edge that actually advances the pipe.
  assign bubble   = de_v & reg_dep & ~flush & ~mem_stall;
  assign de_stall = mem_stall | (de_v & reg_dep & ~flush);

  genvar gi;
  generate
    for (gi = 0; gi < N_STAGES; gi++) begin : g_stage
      if (gi == ST_AG) begin : g_src_de
        assign stage_in[gi] = {de_v, de_we, de_rmsel, de_modrm};
      end else begin : g_src_prev
        assign stage_in[gi] = stage_q[gi-1];
      end

      dep_stage_reg #(.W(EW)) u_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .hold  (mem_stall),
        .kill  ((gi == ST_AG) ? (flush | bubble) : flush),
        .d_in  (stage_in[gi]),
        .q     (stage_q[gi])
      );
    end
  endgenerate

  assign ag_v     = stage_q[ST_AG][V_B];
  assign v_ag_we  = stage_q[ST_AG][V_B] & stage_q[ST_AG][WE_B];
  assign v_mr_we  = stage_q[ST_MR][V_B] & stage_q[ST_MR][WE_B];
  assign v_ex_we  = stage_q[ST_EX][V_B] & stage_q[ST_EX][WE_B];
  assign v_mw_we  = stage_q[ST_MW][V_B] & stage_q[ST_MW][WE_B];
  assign ag_rmsel = stage_q[ST_AG][RMS_B];
  assign mr_rmsel = stage_q[ST_MR][RMS_B];
  assign ex_rmsel = stage_q[ST_EX][RMS_B];
  assign mw_rmsel = stage_q[ST_MW][RMS_B];
  assign ag_modrm = stage_q[ST_AG][MODRM_W-1:0];
  assign mr_modrm = stage_q[ST_MR][MODRM_W-1:0];
  assign ex_modrm = stage_q[ST_EX][MODRM_W-1:0];
  assign mw_modrm = stage_q[ST_MW][MODRM_W-1:0];

`ifdef DEP_STALL_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Saturating: sticks at all-ones until reset.
  always_comb begin
    cnt_d = cnt_q;
    if (bubble && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bubble_cnt = cnt_q;
`else
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_dep_track_pipe.sv
// Randomized plus directed bench for dep_track_pipe against a stage-list reference model.
module tb_dep_track_pipe;
  import dep_track_pipe_pkg::*;

  localparam int CNT_W = 3;

  logic             clk;
  logic             rst_n;
  logic             de_v, de_we, de_rmsel;
  logic [7:0]       de_modrm;
  logic             reg_dep, mem_stall, flush;
  logic             de_stall, ag_v;
  logic             v_ag_we, v_mr_we, v_ex_we, v_mw_we;
  logic             ag_rmsel, mr_rmsel, ex_rmsel, mw_rmsel;
  logic [7:0]       ag_modrm, mr_modrm, ex_modrm, mw_modrm;
  logic [CNT_W-1:0] bubble_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  stage_entry_t m_st [N_STAGES];
  int           m_cnt;

  dep_track_pipe #(.MODRM_W(8), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .de_v       (de_v),
    .de_we      (de_we),
    .de_rmsel   (de_rmsel),
    .de_modrm   (de_modrm),
    .reg_dep    (reg_dep),
    .mem_stall  (mem_stall),
    .flush      (flush),
    .de_stall   (de_stall),
    .ag_v       (ag_v),
    .v_ag_we    (v_ag_we),
    .v_mr_we    (v_mr_we),
    .v_ex_we    (v_ex_we),
    .v_mw_we    (v_mw_we),
    .ag_rmsel   (ag_rmsel),
    .mr_rmsel   (mr_rmsel),
    .ex_rmsel   (ex_rmsel),
    .mw_rmsel   (mw_rmsel),
    .ag_modrm   (ag_modrm),
    .mr_modrm   (mr_modrm),
    .ex_modrm   (ex_modrm),
    .mw_modrm   (mw_modrm),
    .bubble_cnt (bubble_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int cnt_max();
    return (1 << CNT_W) - 1;
  endfunction

  // Reference: advance the list of in-flight writers according to the edge's priority.
  task automatic model_edge();
    stage_entry_t de_e;
    de_e = '{v: de_v, we: de_we, rmsel: de_rmsel, modrm: de_modrm};
    if (!rst_n) begin
      for (int i = 0; i < N_STAGES; i++) m_st[i] = '0;
      m_cnt = 0;
    end else if (flush) begin
      for (int i = 0; i < N_STAGES; i++) m_st[i].v = 1'b0;
    end else if (mem_stall) begin
      // nothing moves
    end else begin
      for (int i = N_STAGES - 1; i > 0; i--) m_st[i] = m_st[i-1];
      if (de_v && reg_dep) begin
        m_st[ST_AG].v = 1'b0;
`ifdef DEP_STALL_CNT_EN
        if (m_cnt < cnt_max()) m_cnt++;
`endif
      end else begin
        m_st[ST_AG] = de_e;
      end
    end
  endtask

  task automatic check_outputs();
    check_val("ag_v",    {31'd0, ag_v},    {31'd0, m_st[ST_AG].v});
    check_val("v_ag_we", {31'd0, v_ag_we}, {31'd0, m_st[ST_AG].v & m_st[ST_AG].we});
    check_val("v_mr_we", {31'd0, v_mr_we}, {31'd0, m_st[ST_MR].v & m_st[ST_MR].we});
    check_val("v_ex_we", {31'd0, v_ex_we}, {31'd0, m_st[ST_EX].v & m_st[ST_EX].we});
    check_val("v_mw_we", {31'd0, v_mw_we}, {31'd0, m_st[ST_MW].v & m_st[ST_MW].we});
    if (m_st[ST_AG].v) check_val("ag_fields", {23'd0, ag_rmsel, ag_modrm}, {23'd0, m_st[ST_AG].rmsel, m_st[ST_AG].modrm});
    if (m_st[ST_MR].v) check_val("mr_fields", {23'd0, mr_rmsel, mr_modrm}, {23'd0, m_st[ST_MR].rmsel, m_st[ST_MR].modrm});
    if (m_st[ST_EX].v) check_val("ex_fields", {23'd0, ex_rmsel, ex_modrm}, {23'd0, m_st[ST_EX].rmsel, m_st[ST_EX].modrm});
    if (m_st[ST_MW].v) check_val("mw_fields", {23'd0, mw_rmsel, mw_modrm}, {23'd0, m_st[ST_MW].rmsel, m_st[ST_MW].modrm});
    check_val("bubble_cnt", 32'(bubble_cnt), 32'(m_cnt));
  endtask

  // One transaction: drive, check combinational stall, clock, check registered state.
  task automatic step(input logic rn, input logic dv, input logic dwe, input logic drm,
                      input logic [7:0] dm, input logic rdep, input logic ms, input logic fl);
    rst_n = rn; de_v = dv; de_we = dwe; de_rmsel = drm; de_modrm = dm;
    reg_dep = rdep; mem_stall = ms; flush = fl;
    #1;
    check_val("de_stall", {31'd0, de_stall}, {31'd0, ms | (dv & rdep & ~fl)});
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    $display("cyc %0d rst_n=%0b de_v=%0b we=%0b modrm=%02h dep=%0b ms=%0b fl=%0b stall=%0b -> ag_v=%0b we[ag,mr,ex,mw]=%0b%0b%0b%0b cnt=%0d",
             cyc, rn, dv, dwe, dm, rdep, ms, fl, de_stall, ag_v, v_ag_we, v_mr_we, v_ex_we, v_mw_we, bubble_cnt);
    cyc++;
  endtask

  initial begin
    int exp_bub;
    for (int i = 0; i < N_STAGES; i++) m_st[i] = '0;
    m_cnt = 0;
    rst_n = 1'b0; de_v = 1'b0; de_we = 1'b0; de_rmsel = 1'b0; de_modrm = 8'h00;
    reg_dep = 1'b0; mem_stall = 1'b0; flush = 1'b0;

    // Reset held two cycles with a valid decode present.
    repeat (2) step(1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    check_val("rst_mw_modrm", {24'd0, mw_modrm}, 32'h0);
    check_val("rst_ag_modrm", {24'd0, ag_modrm}, 32'h0);

    // Single writer walks AG..MW one stage per edge.
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'hC1, 1'b0, 1'b0, 1'b0);
    check_val("stream_ag", {23'd0, v_ag_we, ag_modrm}, {23'd0, 1'b1, 8'hC1});
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check_val("stream_mw", {23'd0, v_mw_we, mw_modrm}, {23'd0, 1'b1, 8'hC1});

    // Fill, then three dependency bubbles.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'(i), 8'(8'hA0 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 8'h55, 1'b1, 1'b0, 1'b0);
`ifdef DEP_STALL_CNT_EN
    exp_bub = 3;
`else
    exp_bub = 0;
`endif
    check_val("dep_cnt3", 32'(bubble_cnt), 32'(exp_bub));

    // mem_stall together with reg_dep freezes everything.
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 8'h66, 1'b1, 1'b1, 1'b0);
    check_val("ms_cnt_hold", 32'(bubble_cnt), 32'(exp_bub));

    // Refill and flush with reg_dep asserted.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'h77, 1'b1, 1'b1, 1'b1);
    check_val("flush_vals", {28'd0, ag_v, v_mr_we, v_ex_we, v_mw_we}, 32'h0);
    check_val("flush_cnt", 32'(bubble_cnt), 32'(exp_bub));

    // Saturation: many more bubbles than the counter can hold.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0);
`ifdef DEP_STALL_CNT_EN
    check_val("sat_cnt", 32'(bubble_cnt), 32'(cnt_max()));
`else
    check_val("sat_cnt", 32'(bubble_cnt), 32'h0);
`endif

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 63) != 0), 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
